// File: rtl/clks_mem_trans.sv
// Word-rate clock divider (clk/2, clk/4, clk/8) plus a small file of DW-bit
// power/transition counters behind one shared bidirectional data bus.
module clks_mem_trans #(
  parameter int NDIR         = 4,
  parameter int NUM_PWR_CNTR = 15,
  parameter int DW           = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enb,
  output logic            clk10,
  output logic            clk20,
  output logic            clk40,
  input  logic [NDIR:0]   dir,
  input  logic            LE,
  inout  wire  [DW-1:0]   dato
);

  localparam int NENT = NUM_PWR_CNTR + 1;

  // ---------------------------------------------------------------------------
  // Divider: the word clocks are plain bits of one free-running counter, so
  // they stay phase-aligned and never pass through combinational gating.
  // ---------------------------------------------------------------------------
  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (enb) cnt_d = cnt_q + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 3'd0;
    else     cnt_q <= cnt_d;
  end

  assign clk10 = cnt_q[0];
  assign clk20 = cnt_q[1];
  assign clk40 = cnt_q[2];

  // ---------------------------------------------------------------------------
  // Counter file
  // ---------------------------------------------------------------------------
  logic [NENT-1:0][DW-1:0] mem_q, mem_d;
  logic [NENT-1:0]         hit;
  logic [DW-1:0]           rd_data;

  // One-hot decode; out-of-range addresses hit nothing, which drops the
  // write and makes the read return zero.
  for (genvar i = 0; i < NENT; i++) begin : g_dec
    assign hit[i] = (dir == (NDIR+1)'(i));
  end

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < NENT; i++)
      if (!LE && hit[i]) mem_d[i] = dato;
  end

  always_ff @(posedge clk) begin
    if (rst) mem_q <= '0;
    else     mem_q <= mem_d;
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NENT; i++)
      if (hit[i]) rd_data = mem_q[i];
  end

  // Block owns the bus only while reading.
  assign dato = LE ? rd_data : {DW{1'bz}};

endmodule

// File: tb/tb_clks_mem_trans.sv
// Directed bench for clks_mem_trans: divider sequence, enable hold, mid-count
// reset, counter-file write/read, out-of-range access and clearing.
module tb_clks_mem_trans;

  localparam int NDIR = 4;
  localparam int NPC  = 15;
  localparam int DW   = 32;

  logic          clk = 1'b0;
  logic          rst, enb, LE;
  logic [NDIR:0] dir;
  logic [DW-1:0] drv;
  logic          clk10, clk20, clk40;
  wire  [DW-1:0] dato;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // External side drives only while writing.
  assign dato = LE ? {DW{1'bz}} : drv;

  clks_mem_trans #(.NDIR(NDIR), .NUM_PWR_CNTR(NPC), .DW(DW)) dut (
    .clk(clk), .rst(rst), .enb(enb),
    .clk10(clk10), .clk20(clk20), .clk40(clk40),
    .dir(dir), .LE(LE), .dato(dato)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] clks();
    return {29'd0, clk40, clk20, clk10};
  endfunction

  initial begin
    rst = 1'b1; enb = 1'b0; LE = 1'b0; dir = '0; drv = '0;

    // reset, then 16 counting cycles: outputs follow cnt = i mod 8
    @(negedge clk); @(negedge clk);
    check("reset_clks", clks(), 32'd0);
    rst = 1'b0; enb = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      check($sformatf("div_cyc%0d", i), clks(), 32'(i % 8));
    end

    // enable hold: cnt reaches 5, freezes for 4 cycles, then continues at 6
    for (int i = 1; i <= 5; i++) @(negedge clk);
    check("hold_cnt5", clks(), 32'd5);
    enb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("hold_frozen%0d", i), clks(), 32'd5);
    end
    enb = 1'b1;
    @(negedge clk);
    check("hold_resume", clks(), 32'd6);

    // reset mid-count with enb high
    rst = 1'b1;
    @(negedge clk);
    check("midrst_zero", clks(), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_restart", clks(), 32'd1);
    enb = 1'b0;

    // write sweep; bus carries the external value while LE=0
    LE = 1'b0;
    for (int d = 0; d <= NPC; d++) begin
      dir = (NDIR+1)'(d); drv = 32'h100 + 32'(d);
      #1 check($sformatf("wr_bus%0d", d), dato, 32'h100 + 32'(d));
      @(negedge clk);
    end

    // combinational read sweep (no clock edges)
    LE = 1'b1;
    for (int d = 0; d <= NPC; d++) begin
      dir = (NDIR+1)'(d);
      #1 check($sformatf("rd%0d", d), dato, 32'h100 + 32'(d));
    end
    dir = 5'd16; #1 check("rd_oor16", dato, 32'd0);
    dir = 5'd31; #1 check("rd_oor31", dato, 32'd0);

    // out-of-range write ignored
    @(negedge clk);
    LE = 1'b0; dir = 5'd20; drv = 32'hDEADBEEF;
    @(negedge clk);
    LE = 1'b1;
    #1 check("oor_rd20", dato, 32'd0);
    for (int d = 0; d <= NPC; d++) begin
      dir = (NDIR+1)'(d);
      #1 check($sformatf("oor_keep%0d", d), dato, 32'h100 + 32'(d));
    end

    // rst with LE=1: old contents until the edge, zero after
    @(negedge clk);
    dir = 5'd3; rst = 1'b1;
    #1 check("rstrd_pre", dato, 32'h103);
    @(negedge clk);
    check("rstrd_post", dato, 32'd0);
    rst = 1'b0;
    for (int d = 0; d <= NPC; d++) begin
      dir = (NDIR+1)'(d);
      #1 check($sformatf("rst_clr%0d", d), dato, 32'd0);
    end

    // refill with a different pattern, then clear by writing zeros
    @(negedge clk);
    LE = 1'b0;
    for (int d = 0; d <= NPC; d++) begin
      dir = (NDIR+1)'(d); drv = 32'hA5A50000 | 32'(d);
      @(negedge clk);
    end
    LE = 1'b1; dir = 5'd7;
    #1 check("refill7", dato, 32'hA5A50007);
    @(negedge clk);
    LE = 1'b0; drv = 32'd0;
    for (int d = 0; d <= NPC; d++) begin
      dir = (NDIR+1)'(d);
      @(negedge clk);
    end
    LE = 1'b1;
    for (int d = 0; d <= NPC; d++) begin
      dir = (NDIR+1)'(d);
      #1 check($sformatf("wclr%0d", d), dato, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
